memory_router: RTL and testbench

- Parametrised CPU-side memory router.
- Decodes one CPU address space into NUM_REGIONS memory regions. Typical regions: SDRAM, SPI flash, VRAM banks, ROM.
- Issues a single-cycle start to the selected region and rebases the address to a region-relative offset.
- Completes each access either on a region-ready handshake or after a fixed per-region latency.
- Adds the following:
  - unmapped-address error
  - per-access timeout
  - init gating
  - a re-arm rule so a held start never double-issues.

---
 rtl/memory_router.sv | 208 ++++++++++++++++++++
 tb/tb_memory_router.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_router.sv
// memory_router: decodes the CPU address space into NUM_REGIONS regions,
// issues a one-cycle start to the selected region with a rebased address,
// and completes on region ready or after a fixed per-region latency.
// Unmapped addresses and accesses that run past TIMEOUT complete with an error.
module memory_router #(
    parameter int NUM_REGIONS = 4,
    parameter int AW = 27,
    parameter int DW = 32,
    parameter logic [NUM_REGIONS*AW-1:0] REGION_BASE = {27'hC00410, 27'hC00000, 27'h800000, 27'h0},
    parameter logic [NUM_REGIONS*AW-1:0] REGION_SIZE = {27'hFF0, 27'h410, 27'h400000, 27'h800000},
    parameter logic [NUM_REGIONS*8-1:0]  REGION_LAT  = {8'd1, 8'd1, 8'd0, 8'd0},
    parameter int TIMEOUT = 1023
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [AW-1:0]             cpu_addr,
    input  logic [DW-1:0]             cpu_d,
    input  logic                      cpu_we,
    input  logic                      cpu_start,
    output logic                      busy,
    output logic                      done,
    output logic [DW-1:0]             q,
    output logic                      err,
    output logic [1:0]                err_code,
    input  logic [NUM_REGIONS-1:0]    init_in,
    output logic                      init_done,
    output logic [NUM_REGIONS-1:0]    reg_start,
    output logic                      reg_we,
    output logic [AW-1:0]             reg_addr,
    output logic [DW-1:0]             reg_d,
    input  logic [NUM_REGIONS*DW-1:0] reg_q,
    input  logic [NUM_REGIONS-1:0]    reg_ready
);

    localparam int IW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    // Counter wide enough for both TIMEOUT and any 8-bit latency, plus a spare bit.
    localparam int CW = (($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    localparam logic [1:0] E_OK       = 2'd0;
    localparam logic [1:0] E_UNMAPPED = 2'd1;
    localparam logic [1:0] E_TIMEOUT  = 2'd2;

    logic [2:0]             state_q, state_d;
    logic [IW-1:0]          hit_q, hit_d;
    logic                   mapped_q, mapped_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DW-1:0]          q_q, q_d;
    logic                   err_q, err_d;
    logic [1:0]             err_code_q, err_code_d;
    logic [NUM_REGIONS-1:0] reg_start_q, reg_start_d;
    logic                   reg_we_q, reg_we_d;
    logic [AW-1:0]          reg_addr_q, reg_addr_d;
    logic [DW-1:0]          reg_d_q, reg_d_d;

    logic                   dec_hit;
    logic [IW-1:0]          dec_idx;
    logic [AW-1:0]          dec_off;
    logic [DW-1:0]          sel_q;
    logic                   sel_ready;
    logic [7:0]             sel_lat;
    logic [CW-1:0]          lat_ext;

    assign init_done = &init_in;
    assign busy      = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign done      = (state_q == S_DONE);
    assign q         = q_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign reg_start = reg_start_q;
    assign reg_we    = reg_we_q;
    assign reg_addr  = reg_addr_q;
    assign reg_d     = reg_d_q;
    assign lat_ext   = CW'(sel_lat);

    // Address decode; descending scan so the lowest matching index is kept.
    // Bounds are AW+1 bits wide so base+size cannot wrap.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        dec_off = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (({1'b0, cpu_addr} >= {1'b0, REGION_BASE[i*AW +: AW]}) &&
                ({1'b0, cpu_addr} <  ({1'b0, REGION_BASE[i*AW +: AW]} +
                                      {1'b0, REGION_SIZE[i*AW +: AW]}))) begin
                dec_hit = 1'b1;
                dec_idx = IW'(i);
                dec_off = cpu_addr - REGION_BASE[i*AW +: AW];
            end
        end
    end

    // Mux the latched region's read data, ready and latency setting.
    always_comb begin
        sel_q     = '0;
        sel_ready = 1'b0;
        sel_lat   = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (hit_q == IW'(i)) begin
                sel_q     = reg_q[i*DW +: DW];
                sel_ready = reg_ready[i];
                sel_lat   = REGION_LAT[i*8 +: 8];
            end
        end
    end

    // Access sequencer: IDLE -> ISSUE -> WAIT -> DONE -> (HOLD) -> IDLE.
    always_comb begin
        state_d     = state_q;
        hit_d       = hit_q;
        mapped_d    = mapped_q;
        cnt_d       = cnt_q;
        q_d         = q_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        reg_start_d = '0;
        reg_we_d    = reg_we_q;
        reg_addr_d  = reg_addr_q;
        reg_d_d     = reg_d_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_start && init_done) begin
                    state_d     = S_ISSUE;
                    hit_d       = dec_idx;
                    mapped_d    = dec_hit;
                    reg_we_d    = cpu_we;
                    reg_addr_d  = dec_off;
                    reg_d_d     = cpu_d;
                    err_d       = 1'b0;
                    err_code_d  = E_OK;
                    // Start flop is loaded here so it is high exactly during ISSUE.
                    reg_start_d = dec_hit ? (NUM_REGIONS'(1) << dec_idx) : '0;
                end
            end
            S_ISSUE: begin
                if (mapped_q) begin
                    state_d = S_WAIT;
                    cnt_d   = CW'(1);
                end else begin
                    state_d    = S_DONE;
                    q_d        = '0;
                    err_d      = 1'b1;
                    err_code_d = E_UNMAPPED;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if ((sel_lat != 8'd0) ? (cnt_q == lat_ext) : sel_ready) begin
                    state_d = S_DONE;
                    if (!reg_we_q) begin
                        q_d = sel_q;
                    end
                end else if (cnt_q >= CW'(TIMEOUT)) begin
                    state_d    = S_DONE;
                    q_d        = '0;
                    err_d      = 1'b1;
                    err_code_d = E_TIMEOUT;
                end
            end
            S_DONE: begin
                state_d = cpu_start ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (!cpu_start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            hit_q       <= '0;
            mapped_q    <= 1'b0;
            cnt_q       <= '0;
            q_q         <= '0;
            err_q       <= 1'b0;
            err_code_q  <= E_OK;
            reg_start_q <= '0;
            reg_we_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_d_q     <= '0;
        end else begin
            state_q     <= state_d;
            hit_q       <= hit_d;
            mapped_q    <= mapped_d;
            cnt_q       <= cnt_d;
            q_q         <= q_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            reg_start_q <= reg_start_d;
            reg_we_q    <= reg_we_d;
            reg_addr_q  <= reg_addr_d;
            reg_d_q     <= reg_d_d;
        end
    end

endmodule

// File: tb/tb_memory_router.sv
// Testbench for memory_router: directed scenarios plus randomized accesses,
// with expected responses queued by the driver and checked by a monitor.
module tb_memory_router;

    localparam int NR  = 4;
    localparam int AW  = 27;
    localparam int DW  = 32;
    localparam int TMO = 8;

    // Region map as plain numbers, index = region number.
    localparam longint M_BASE [4] = '{64'h0, 64'h800000, 64'hC00000, 64'hC00410};
    localparam longint M_SIZE [4] = '{64'h800000, 64'h400000, 64'h410, 64'hFF0};
    localparam int     M_LAT  [4] = '{0, 0, 1, 1};

    typedef struct {
        logic [DW-1:0] q;
        logic          err;
        logic [1:0]    code;
        logic          mapped;
        logic [NR-1:0] onehot;
        logic [AW-1:0] off;
        logic          we;
        logic [DW-1:0] d;
        int            issue_cyc;
        int            done_cyc;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [AW-1:0]    cpu_addr;
    logic [DW-1:0]    cpu_d;
    logic             cpu_we;
    logic             cpu_start;
    logic             busy;
    logic             done;
    logic [DW-1:0]    q;
    logic             err;
    logic [1:0]       err_code;
    logic [NR-1:0]    init_in;
    logic             init_done;
    logic [NR-1:0]    reg_start;
    logic             reg_we;
    logic [AW-1:0]    reg_addr;
    logic [DW-1:0]    reg_d;
    logic [NR*DW-1:0] reg_q;
    logic [NR-1:0]    reg_ready;

    int            vectors     = 0;
    int            miscompares = 0;
    int            cyc         = 0;
    int            starts_seen = 0;
    logic [DW-1:0] model_q     = '0;
    exp_t          sbq[$];

    memory_router #(
        .NUM_REGIONS(NR),
        .AW(AW),
        .DW(DW),
        .REGION_BASE({27'hC00410, 27'hC00000, 27'h800000, 27'h0}),
        .REGION_SIZE({27'hFF0, 27'h410, 27'h400000, 27'h800000}),
        .REGION_LAT({8'd1, 8'd1, 8'd0, 8'd0}),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cpu_addr(cpu_addr),
        .cpu_d(cpu_d),
        .cpu_we(cpu_we),
        .cpu_start(cpu_start),
        .busy(busy),
        .done(done),
        .q(q),
        .err(err),
        .err_code(err_code),
        .init_in(init_in),
        .init_done(init_done),
        .reg_start(reg_start),
        .reg_we(reg_we),
        .reg_addr(reg_addr),
        .reg_d(reg_d),
        .reg_q(reg_q),
        .reg_ready(reg_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue one access; the expectation comes from the region table and the
    // access rules, then the bench plays the region side and the CPU side.
    task automatic do_access(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we,
                             input logic [NR*DW-1:0] rq, input int rdy_at,
                             input int hold_extra, input bit early);
        exp_t   e;
        int     r;
        int     lat;
        int     c0;
        int     k;
        int     kd;
        int     rb;
        bit     seen;
        bit     fin;
        longint av;
        av = longint'(a);
        r  = -1;
        for (int i = 0; i < NR; i++) begin
            if (r < 0 && av >= M_BASE[i] && av < M_BASE[i] + M_SIZE[i]) r = i;
        end
        c0       = cyc;
        e.mapped = (r >= 0);
        e.we     = we;
        e.d      = d;
        e.err    = 1'b0;
        e.code   = 2'd0;
        if (r < 0) begin
            e.onehot = '0;
            e.off    = '0;
            e.q      = '0;
            e.err    = 1'b1;
            e.code   = 2'd1;
            lat      = 2;
            rb       = 0;
        end else begin
            e.onehot = NR'(1 << r);
            e.off    = AW'(av - M_BASE[r]);
            rb       = r;
            if (M_LAT[r] > 0 || (rdy_at >= 1 && rdy_at <= TMO)) begin
                lat = (M_LAT[r] > 0) ? M_LAT[r] + 2 : rdy_at + 2;
                e.q = we ? model_q : rq[r*DW +: DW];
            end else begin
                lat    = TMO + 2;
                e.q    = '0;
                e.err  = 1'b1;
                e.code = 2'd2;
            end
        end
        model_q     = e.q;
        e.issue_cyc = c0 + 1;
        e.done_cyc  = c0 + lat;
        sbq.push_back(e);

        cpu_addr  = a;
        cpu_d     = d;
        cpu_we    = we;
        cpu_start = 1'b1;
        init_in   = '1;
        reg_q     = rq;
        reg_ready = '0;
        seen      = 1'b0;
        fin       = 1'b0;
        kd        = 0;
        for (int t = 0; t < 80 && !fin; t++) begin
            @(negedge clk);
            k = cyc - c0;
            // CPU-side inputs wander after accept; init may drop mid-access.
            cpu_addr  = AW'($urandom);
            cpu_d     = $urandom;
            cpu_we    = 1'($urandom);
            init_in   = seen ? '1 : NR'($urandom);
            reg_ready = '0;
            if (early && k == 1) reg_ready[rb] = 1'b1;
            if (rdy_at > 0 && k == 1 + rdy_at) reg_ready[rb] = 1'b1;
            if (!seen && done) begin
                seen = 1'b1;
                kd   = k;
            end
            if (seen && k >= kd + hold_extra) cpu_start = 1'b0;
            if (seen && k >= kd + hold_extra + 1 && k >= rdy_at + 2) fin = 1'b1;
        end
        chk("access_done_seen", 64'(seen), 64'h1);
        if (!fin) begin
            cpu_start   = 1'b0;
            reg_ready   = '0;
            sbq.delete();
            starts_seen = 0;
            repeat (3) @(negedge clk);
        end
    endtask

    // Monitor: checks every region start and every completion against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (reg_start != '0) begin
                    if (sbq.size() == 0) begin
                        chk("spurious_start", 64'(reg_start), 64'h0);
                    end else begin
                        chk("start_onehot", 64'(reg_start), 64'(sbq[0].onehot));
                        chk("start_cycle", 64'(cyc), 64'(sbq[0].issue_cyc));
                        if (sbq[0].mapped) begin
                            chk("issue_addr", 64'(reg_addr), 64'(sbq[0].off));
                            chk("issue_we", 64'(reg_we), 64'(sbq[0].we));
                            chk("issue_d", 64'(reg_d), 64'(sbq[0].d));
                        end
                        starts_seen++;
                    end
                end
                if (done) begin
                    if (sbq.size() == 0) begin
                        chk("spurious_done", 64'(done), 64'h0);
                    end else begin
                        e = sbq.pop_front();
                        chk("done_q", 64'(q), 64'(e.q));
                        chk("done_err", 64'(err), 64'(e.err));
                        chk("done_err_code", 64'(err_code), 64'(e.code));
                        chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
                        chk("done_busy", 64'(busy), 64'h0);
                        chk("start_count", 64'(starts_seen), e.mapped ? 64'h1 : 64'h0);
                        if (e.mapped) begin
                            chk("hold_addr", 64'(reg_addr), 64'(e.off));
                            chk("hold_d", 64'(reg_d), 64'(e.d));
                        end
                        starts_seen = 0;
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [NR*DW-1:0] rq;
        logic [AW-1:0]    bnd [10];
        logic [AW-1:0]    a;
        logic [31:0]      tmp;
        exp_t             e;
        int               c0;

        bnd = '{27'h0, 27'h7FFFFF, 27'h800000, 27'hBFFFFF, 27'hC00000,
                27'hC0040F, 27'hC00410, 27'hC013FF, 27'hC01400, 27'h7FFFFFF};

        reset     = 1'b0;
        cpu_addr  = '0;
        cpu_d     = '0;
        cpu_we    = 1'b0;
        cpu_start = 1'b0;
        init_in   = '1;
        reg_q     = '0;
        reg_ready = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_q", 64'(q), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("rst_err_code", 64'(err_code), 64'h0);
        chk("rst_reg_start", 64'(reg_start), 64'h0);
        chk("rst_reg_we", 64'(reg_we), 64'h0);
        chk("rst_reg_addr", 64'(reg_addr), 64'h0);
        chk("rst_reg_d", 64'(reg_d), 64'h0);
        reset = 1'b1;
        @(negedge clk);

        // Fixed-latency read from region 2.
        rq = {$urandom, 32'hDEADBEEF, $urandom, $urandom};
        do_access(27'hC00005, $urandom, 1'b0, rq, 0, 0, 1'b0);
        // Handshake write to SDRAM, ready on the 5th WAIT cycle, early ready ignored.
        rq = {$urandom, $urandom, $urandom, $urandom};
        do_access(27'h000010, 32'h12345678, 1'b1, rq, 5, 0, 1'b1);
        // First unmapped word.
        do_access(27'hC01400, $urandom, 1'b0, rq, 0, 0, 1'b0);
        // Flash read with no ready: timeout, then a late ready pulse.
        do_access(27'h800003, $urandom, 1'b0, rq, 12, 0, 1'b0);
        // Start held high for 20 cycles.
        do_access(27'hC00410, $urandom, 1'b0, rq, 0, 17, 1'b0);

        // Init gating: start held while one region is not initialised.
        init_in   = 4'b1011;
        cpu_addr  = 27'hC00007;
        cpu_we    = 1'b0;
        cpu_start = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("gated_busy", 64'(busy), 64'h0);
            chk("gated_init_done", 64'(init_done), 64'h0);
        end
        rq = {$urandom, $urandom, $urandom, $urandom};
        do_access(27'hC00007, $urandom, 1'b0, rq, 0, 0, 1'b0);
        chk("init_done_all", 64'(init_done), 64'h1);

        // Randomized accesses.
        for (int n = 0; n < 60; n++) begin
            tmp = $urandom;
            case ($urandom_range(0, 5))
                0: a = AW'($urandom_range(0, 32'h7FFFFF));
                1: a = AW'(32'h800000 + $urandom_range(0, 32'h3FFFFF));
                2: a = AW'(32'hC00000 + $urandom_range(0, 32'h40F));
                3: a = AW'(32'hC00410 + $urandom_range(0, 32'hFEF));
                4: a = bnd[$urandom_range(0, 9)];
                default: a = tmp[AW-1:0];
            endcase
            rq = {$urandom, $urandom, $urandom, $urandom};
            do_access(a, $urandom, 1'($urandom), rq, $urandom_range(0, 10),
                      $urandom_range(0, 3), 1'($urandom));
        end

        // Reset asserted while a handshake access is in WAIT.
        c0          = cyc;
        e.mapped    = 1'b1;
        e.onehot    = 4'b0001;
        e.off       = 27'h100;
        e.we        = 1'b0;
        e.d         = 32'h0BAD0BAD;
        e.q         = '0;
        e.err       = 1'b0;
        e.code      = 2'd0;
        e.issue_cyc = c0 + 1;
        e.done_cyc  = c0 + 100;
        sbq.push_back(e);
        cpu_addr  = 27'h100;
        cpu_d     = 32'h0BAD0BAD;
        cpu_we    = 1'b0;
        cpu_start = 1'b1;
        init_in   = '1;
        reg_ready = '0;
        repeat (4) @(negedge clk);
        chk("abort_busy_pre", 64'(busy), 64'h1);
        reset       = 1'b0;
        cpu_start   = 1'b0;
        sbq.delete();
        starts_seen = 0;
        model_q     = '0;
        #1;
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_done", 64'(done), 64'h0);
        chk("abort_reg_start", 64'(reg_start), 64'h0);
        chk("abort_q", 64'(q), 64'h0);
        chk("abort_err", 64'(err), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("abort_no_done", 64'(done), 64'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
